// File: rtl/key_sched_iter128.sv
`default_nettype none
// ============================================================================
// Module   : key_sched_iter128
// Purpose  : Iterative AES-128 key scheduler, one round key per handshake.
// Revision : 1.0 - initial release
// ============================================================================
module key_sched_iter128 #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key_valid,
    output logic                      key_ready,
    input  logic [KEY_W-1:0]          Key,
    output logic                      rk_valid,
    input  logic                      rk_ready,
    output logic [KEY_W-1:0]          round_key,
    output logic [3:0]                rk_idx,
    output logic                      sched_valid,
    output logic [(NR+1)*KEY_W-1:0]   KeySchedule
);

    localparam logic [3:0] c_LAST_IDX = 4'(NR);

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int pos;
        pos = 2047 - 8 * int'(x);
        return c_SBOX[pos -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [KEY_W-1:0]           rk_q, rk_d;
    logic [3:0]                 idx_q, idx_d;
    logic [7:0]                 rcon_q, rcon_d;
    logic                       sched_valid_q, sched_valid_d;
    logic [(NR+1)*KEY_W-1:0]    sched_q, sched_d;

    // Word 0 / byte 0 sit at the most significant end of the key.
    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;
    logic [KEY_W-1:0] w_next;
    logic [3:0]  w_idx_inc;

    assign w_w0  = rk_q[127:96];
    assign w_w1  = rk_q[95:64];
    assign w_w2  = rk_q[63:32];
    assign w_w3  = rk_q[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_sbox
        assign w_sub[8*k +: 8] = sbox(w_rot[8*k +: 8]);
    end

    assign w_t       = w_sub ^ {rcon_q, 24'h000000};
    assign w_n0      = w_w0 ^ w_t;
    assign w_n1      = w_w1 ^ w_n0;
    assign w_n2      = w_w2 ^ w_n1;
    assign w_n3      = w_w3 ^ w_n2;
    assign w_next    = {w_n0, w_n1, w_n2, w_n3};
    assign w_idx_inc = idx_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        rk_d          = rk_q;
        idx_d         = idx_q;
        rcon_d        = rcon_q;
        sched_valid_d = sched_valid_q;
        sched_d       = sched_q;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    state_d             = S_EMIT;
                    rk_d                = Key;
                    idx_d               = 4'd0;
                    sched_d[0 +: KEY_W] = Key;
                    sched_valid_d       = 1'b0;
                    rcon_d              = 8'h01;
                end
            end
            S_EMIT: begin
                if (rk_ready) begin
                    if (idx_q == c_LAST_IDX) begin
                        state_d       = S_IDLE;
                        sched_valid_d = 1'b1;
                    end else begin
                        rk_d   = w_next;
                        idx_d  = w_idx_inc;
                        rcon_d = xtime(rcon_q);
                        for (int i = 1; i <= NR; i++) begin
                            if (w_idx_inc == 4'(i)) begin
                                sched_d[i*KEY_W +: KEY_W] = w_next;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rk_q          <= '0;
            idx_q         <= 4'd0;
            rcon_q        <= 8'h01;
            sched_valid_q <= 1'b0;
            sched_q       <= '0;
        end else begin
            state_q       <= state_d;
            rk_q          <= rk_d;
            idx_q         <= idx_d;
            rcon_q        <= rcon_d;
            sched_valid_q <= sched_valid_d;
            sched_q       <= sched_d;
        end
    end

    assign key_ready   = (state_q == S_IDLE);
    assign rk_valid    = (state_q == S_EMIT);
    assign round_key   = rk_q;
    assign rk_idx      = idx_q;
    assign sched_valid = sched_valid_q;
    assign KeySchedule = sched_q;

endmodule
`default_nettype wire

// File: tb/tb_key_sched_iter128.sv
`default_nettype none
// Directed bench for key_sched_iter128: FIPS-197 round-key tables plus
// backpressure, ignored-key, reset and back-to-back sequences.
module tb_key_sched_iter128;

    logic          clk;
    logic          rst;
    logic          key_valid;
    logic          key_ready;
    logic [127:0]  Key;
    logic          rk_valid;
    logic          rk_ready;
    logic [127:0]  round_key;
    logic [3:0]    rk_idx;
    logic          sched_valid;
    logic [1407:0] KeySchedule;

    key_sched_iter128 dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .Key         (Key),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .round_key   (round_key),
        .rk_idx      (rk_idx),
        .sched_valid (sched_valid),
        .KeySchedule (KeySchedule)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h5468617473206d79204b756e67204675;

    vec_t         vecs [14];
    logic [127:0] got  [11];
    int           nchecks = 0;
    int           nerrors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic start_key(input logic [127:0] k, input bit hold);
        chk("key_ready_idle", {127'd0, key_ready}, 128'd1);
        key_valid = 1'b1;
        Key       = k;
        @(negedge clk);
        if (!hold) key_valid = 1'b0;
        chk("rk0_valid", {127'd0, rk_valid}, 128'd1);
        chk("rk0_idx", {124'd0, rk_idx}, 128'd0);
        chk("rk0_value", round_key, k);
        chk("sched_cleared", {127'd0, sched_valid}, 128'd0);
    endtask

    // Drains all 11 round keys into got[]; returns the number of cycles taken.
    task automatic collect(input bit stall, input bit inject, input logic [127:0] bad,
                           output int cycles);
        int           n;
        int           stall_left;
        bit           prev_stalled;
        logic [127:0] prev_rk;
        logic [3:0]   prev_idx;
        n            = 0;
        cycles       = 0;
        prev_stalled = 1'b0;
        prev_rk      = '0;
        prev_idx     = '0;
        stall_left   = stall ? int'($urandom_range(0, 5)) : 0;
        while (n < 11 && cycles < 300) begin
            if (prev_stalled) begin
                chk("stall_rk_stable", round_key, prev_rk);
                chk("stall_idx_stable", {124'd0, rk_idx}, {124'd0, prev_idx});
            end
            chk("emit_flags", {125'd0, key_ready, rk_valid, sched_valid}, 128'b010);
            if (inject) begin
                key_valid = (n == 3);
                Key       = (n == 3) ? bad : Key;
            end
            if (stall_left > 0) begin
                rk_ready = 1'b0;
                stall_left--;
            end else begin
                rk_ready = 1'b1;
                chk($sformatf("rk_idx_order_%0d", n), {124'd0, rk_idx}, 128'(n));
                got[n] = round_key;
                n++;
                if (stall) stall_left = int'($urandom_range(0, 5));
            end
            prev_stalled = !rk_ready;
            prev_rk      = round_key;
            prev_idx     = rk_idx;
            @(negedge clk);
            cycles++;
        end
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        if (n < 11) begin
            nchecks++;
            nerrors++;
            $display("FAIL collect_timeout: got %0d keys expected 11", n);
        end
        if (!stall) chk("sched_latency", 128'(cycles), 128'd11);
        chk("done_flags", {125'd0, key_ready, rk_valid, sched_valid}, 128'b101);
    endtask

    task automatic check_table(input logic [127:0] k);
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].key == k) begin
                chk($sformatf("rk_emitted_%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].rk);
                chk($sformatf("sched_slot_%0d", vecs[i].idx),
                    KeySchedule[128*vecs[i].idx +: 128], vecs[i].rk);
            end
        end
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{K1, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{K1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{K1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{K1, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[4]  = '{K1, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[5]  = '{K1, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{K1, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[7]  = '{K1, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[8]  = '{K1, 8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[9]  = '{K1, 9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[10] = '{K1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[11] = '{K2, 0,  128'h5468617473206d79204b756e67204675};
        vecs[12] = '{K2, 1,  128'he232fcf191129188b159e4e6d679a293};
        vecs[13] = '{K2, 10, 128'h28fddef86da4244accc0a4fe3b316f26};

        rst       = 1'b1;
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        Key       = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {125'd0, key_ready, rk_valid, sched_valid}, 128'b100);
        chk("reset_idx", {124'd0, rk_idx}, 128'd0);
        chk("reset_rk", round_key, 128'd0);
        chk("reset_sched", {127'd0, |KeySchedule}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1 and 2: straight runs with rk_ready held high.
        start_key(K1, 1'b0);
        collect(1'b0, 1'b0, '0, cyc);
        check_table(K1);
        start_key(K2, 1'b0);
        collect(1'b0, 1'b0, '0, cyc);
        check_table(K2);

        // Scenario 3: random backpressure.
        start_key(K1, 1'b0);
        collect(1'b1, 1'b0, '0, cyc);
        check_table(K1);

        // Scenario 4: a different key offered mid-schedule must be ignored.
        start_key(K1, 1'b0);
        collect(1'b0, 1'b1, K2, cyc);
        check_table(K1);

        // Scenario 5: reset while rk_idx == 5, then reset colliding with a key handshake.
        start_key(K1, 1'b0);
        for (int c = 0; c < 50 && rk_idx != 4'd5; c++) @(negedge clk);
        chk("reach_idx5", {124'd0, rk_idx}, 128'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_emit_flags", {125'd0, key_ready, rk_valid, sched_valid}, 128'b100);
        chk("rst_emit_idx", {124'd0, rk_idx}, 128'd0);
        key_valid = 1'b1;
        Key       = K2;
        @(negedge clk);
        chk("rst_wins_flags", {125'd0, key_ready, rk_valid, sched_valid}, 128'b100);
        key_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        start_key(K1, 1'b0);
        collect(1'b0, 1'b0, '0, cyc);
        check_table(K1);

        // Scenario 6: key_valid held high across two keys.
        start_key(K1, 1'b1);
        Key = K2;
        collect(1'b0, 1'b0, '0, cyc);
        key_valid = 1'b1;
        check_table(K1);
        @(negedge clk);
        key_valid = 1'b0;
        chk("b2b_flags", {125'd0, key_ready, rk_valid, sched_valid}, 128'b010);
        chk("b2b_idx", {124'd0, rk_idx}, 128'd0);
        chk("b2b_rk0", round_key, K2);
        collect(1'b0, 1'b0, '0, cyc);
        check_table(K2);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire
